lcd_touch_pio_in: RTL and testbench
===================================

// Module: lcd_touch_pio_in
// PURPOSE
//  Avalon-MM input port: the read-side counterpart of the LCD touch-panel output PIOs (SCL drive).
//  Samples the panel's external lines (touch INT_n, SDA readback) through a synchronizer.
//  Provides CPU-readable level, per-bit edge capture and a maskable interrupt for the Nios II I2C/touch driver.
//  Sits in the SOPC fabric beside the SCL/SDA output ports; one instance per input group.
// PARAMETERS
//  WIDTH        1  number of input bits (1..32)
//  SYNC_STAGES  2  synchronizer flops per bit (2..4)
//  EDGE_TYPE    1  0=rising, 1=falling, 2=any edge captured
// PORTS
//  clk        in   1      system clock
//  reset      in   1      synchronous, active-high reset
//  address    in   3      word address: 0=data, 2=irqmask, 3=edgecapture; others read 0
//  chipselect in   1      slave select
//  read_n     in   1      read strobe, active-low
//  write_n    in   1      write strobe, active-low
//  writedata  in   32     write data; bits above WIDTH ignored
//  readdata   out  32     read data, registered, bits above WIDTH are 0
//  in_port    in   WIDTH  asynchronous external inputs
//  irq        out  1      level interrupt = |(edgecapture & irqmask)
// BEHAVIOUR
//  - Reset: sync chain, edge_capture, irq_mask, readdata, irq all 0; warm-up counter cleared.
//  - Synchronizer: in_port -> SYNC_STAGES flops -> d_sync; one extra flop d_prev for edge detect.
//  - Warm-up: counter counts 0..SYNC_STAGES+1 after reset, then saturates; edge detection is
//    suppressed until saturation (prevents false edges while the chain flushes reset zeros).
//  - Edge detect per bit: rise=d_sync&~d_prev, fall=~d_sync&d_prev, per EDGE_TYPE.
//  - Input-to-capture latency: pin change visible in edge_capture SYNC_STAGES+1 cycles later.
//  - Read (chipselect & ~read_n): readdata registered the next cycle (read latency 1);
//    addr0 -> d_sync, addr2 -> irq_mask, addr3 -> edge_capture, other -> 0. Not a clear-on-read.
//  - Write (chipselect & ~write_n): addr2 loads irq_mask; addr3 is write-1-to-clear on
//    edge_capture; writes to addr0 and other addresses ignored.
//  - Simultaneous edge and W1C on the same bit in the same cycle: edge wins, bit stays 1.
//  - Simultaneous read and write to same address: readdata returns the pre-write value.
//  - edge_capture bits are sticky; repeated edges do not toggle or count.
//  - irq is registered: asserts 1 cycle after the enabling edge_capture/irq_mask update;
//    deasserts 1 cycle after the last masked bit is cleared.
//  - Reset asserted mid-operation: all state returns to reset values next edge, warm-up restarts.
//  - read_n and write_n both low: both performed, each per rules above.
// CONFIGURATION
//  LCD_TOUCH_PIO_IRQ_EN defined: irq_mask register and irq output as above.
//  Not defined: no mask register (addr2 reads 0, writes ignored), irq tied 0;
//  edge_capture still present and polled by software.
// TESTING
//  1. Reset with in_port=1, EDGE_TYPE=1: hold 10 cycles -> edge_capture=0, irq=0, addr0 reads 1.
//  2. in_port 1->0 after warm-up -> edge_capture[0]=1 exactly 3 cycles later (SYNC_STAGES=2).
//  3. irq_mask=1 then falling edge -> irq=1; write 0x1 to addr3 -> irq=0 one cycle after.
//  4. W1C on addr3 in the same cycle a new edge lands -> edge_capture[0] remains 1.
//  5. Read addr0/2/3/5 -> readdata valid one cycle after strobe; addr5 returns 0x00000000.
//  6. Build without LCD_TOUCH_PIO_IRQ_EN: write 0x1 to addr2, edge occurs -> irq=0, addr2 reads 0.

Source files
------------

// File: rtl/lcd_touch_pio_in_if.sv
// lcd_touch_pio_in_if: Avalon-MM slave bus and irq for the touch-panel input PIO.
interface lcd_touch_pio_in_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  modport master (output address, chipselect, read_n, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, read_n, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/lcd_touch_pio_in.sv
// lcd_touch_pio_in: synchronized input PIO with sticky edge capture; LCD_TOUCH_PIO_IRQ_EN adds irq_mask and irq.
module lcd_touch_pio_in #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_touch_pio_in_if.slave    bus,
  input  logic [WIDTH-1:0]     in_port
);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] WARM = CW'(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] d_sync, d_prev, rise, fall, edge_det, edge_capture, irq_mask, w1c;
  logic [CW-1:0] warm_cnt;
  logic warm, rd, wr;
  logic unused_wd;
  assign unused_wd = ^bus.writedata;
  assign d_sync = sync[SYNC_STAGES-1];
  assign warm = warm_cnt == WARM;
  assign rd = bus.chipselect & ~bus.read_n;
  assign wr = bus.chipselect & ~bus.write_n;
  always_comb begin
    rise = d_sync & ~d_prev;
    fall = ~d_sync & d_prev;
    edge_det = !warm ? '0 : EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : rise | fall;
    w1c = (wr && bus.address == 3'd3) ? bus.writedata[WIDTH-1:0] : '0;
  end
  // a new edge in the same cycle as its W1C keeps the bit set
  always_ff @(posedge clk) begin
    if (reset) begin
      sync         <= '0;
      d_prev       <= '0;
      warm_cnt     <= '0;
      edge_capture <= '0;
      bus.readdata <= '0;
    end else begin
      sync         <= {sync[SYNC_STAGES-2:0], in_port};
      d_prev       <= d_sync;
      warm_cnt     <= warm ? warm_cnt : warm_cnt + 1'b1;
      edge_capture <= (edge_capture & ~w1c) | edge_det;
      if (rd)
        bus.readdata <= bus.address == 3'd0 ? 32'(d_sync) :
                        bus.address == 3'd2 ? 32'(irq_mask) :
                        bus.address == 3'd3 ? 32'(edge_capture) : '0;
    end
  end
`ifdef LCD_TOUCH_PIO_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      bus.irq  <= 1'b0;
    end else begin
      if (wr && bus.address == 3'd2) irq_mask <= bus.writedata[WIDTH-1:0];
      bus.irq <= |(edge_capture & irq_mask);
    end
  end
`else
  assign irq_mask = '0;
  assign bus.irq  = 1'b0;
`endif
endmodule

// File: tb/tb_lcd_touch_pio_in.sv
// tb_lcd_touch_pio_in: directed checks of sync latency, edge capture, W1C, reads and irq.
module tb_lcd_touch_pio_in;
  logic clk = 0;
  logic reset;
  logic [0:0] in_port;
  int vectors = 0;
  int miscompares = 0;
  lcd_touch_pio_in_if bus ();
  lcd_touch_pio_in #(.WIDTH(1), .SYNC_STAGES(2), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .in_port(in_port));
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic bus_idle();
    bus.chipselect = 0; bus.read_n = 1; bus.write_n = 1; bus.address = 0; bus.writedata = 0;
  endtask
  task automatic rd(input logic [2:0] a);
    bus.chipselect = 1; bus.read_n = 0; bus.address = a;
    tick();
    bus_idle();
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1; bus.write_n = 0; bus.address = a; bus.writedata = d;
    tick();
    bus_idle();
  endtask
  initial begin
    bus_idle();
    reset = 1; in_port = 1;
    tick(3);
    check("reset_readdata", bus.readdata, 0);
    check("reset_irq", 32'(bus.irq), 0);
    reset = 0;
    tick(10);
    check("warm_no_edge", 32'(dut.edge_capture), 0);
    rd(3); check("rd_ec_idle", bus.readdata, 0);
    rd(0); check("rd_data_1", bus.readdata, 1);
    rd(5); check("rd_addr5", bus.readdata, 0);
    in_port = 0;
    tick(2); check("fall_lat2", 32'(dut.edge_capture), 0);
    tick(1); check("fall_lat3", 32'(dut.edge_capture), 1);
    rd(3); check("rd_ec_set", bus.readdata, 1);
    rd(3); check("rd_not_clear", bus.readdata, 1);
    rd(0); check("rd_data_0", bus.readdata, 0);
    wr(0, 32'hffff_ffff);
    check("wr_addr0_ignored", 32'(dut.edge_capture), 1);
    wr(3, 1); check("w1c_clear", 32'(dut.edge_capture), 0);
    check("irq_idle", 32'(bus.irq), 0);
    wr(2, 1);
    rd(2);
`ifdef LCD_TOUCH_PIO_IRQ_EN
    check("rd_mask", bus.readdata, 1);
`else
    check("rd_mask_absent", bus.readdata, 0);
`endif
    in_port = 1; tick(5);
    check("rise_ignored", 32'(dut.edge_capture), 0);
    in_port = 0; tick(3);
    check("fall2_ec", 32'(dut.edge_capture), 1);
    check("irq_reg_delay", 32'(bus.irq), 0);
    tick();
`ifdef LCD_TOUCH_PIO_IRQ_EN
    check("irq_assert", 32'(bus.irq), 1);
    wr(3, 1);
    check("irq_hold_after_w1c", 32'(bus.irq), 1);
    tick();
    check("irq_deassert", 32'(bus.irq), 0);
`else
    check("irq_tied0", 32'(bus.irq), 0);
    wr(3, 1);
    check("irq_tied0_b", 32'(bus.irq), 0);
`endif
    check("ec_cleared2", 32'(dut.edge_capture), 0);
    in_port = 1; tick(5);
    in_port = 0; tick(3);
    check("ec_pre_collide", 32'(dut.edge_capture), 1);
    in_port = 1; tick(5);
    check("sticky", 32'(dut.edge_capture), 1);
    in_port = 0; tick(2);
    wr(3, 1);
    check("edge_beats_w1c", 32'(dut.edge_capture), 1);
    bus.chipselect = 1; bus.read_n = 0; bus.write_n = 0; bus.address = 3; bus.writedata = 1;
    tick();
    bus_idle();
    check("rw_pre_value", bus.readdata, 1);
    check("rw_cleared", 32'(dut.edge_capture), 0);
    in_port = 1; tick(5);
    in_port = 0; tick(3);
    rd(0);
    check("pre_reset_ec", 32'(dut.edge_capture), 1);
    reset = 1; tick();
    check("midreset_ec", 32'(dut.edge_capture), 0);
    check("midreset_rd", bus.readdata, 0);
    check("midreset_irq", 32'(bus.irq), 0);
    reset = 0; in_port = 1;
    tick(10);
    check("rewarm_no_edge", 32'(dut.edge_capture), 0);
    rd(2); check("mask_reset", bus.readdata, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
